// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
//   Shared definitions for the vending-machine coin path.
//   - dec_state_t : coin pulse decoder state encoding
//   - COIN5_PULSES / COIN10_PULSES : pulse counts that identify each coin
//   - COIN5_VALUE / COIN10_VALUE   : coin values in units (used by vending_machine)
//   - cnt_sat_inc : saturating increment for the 2-bit pulse counter
// -----------------------------------------------------------------------------
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIGH   = 3'd1,
        ST_GAP    = 3'd2,
        ST_DECODE = 3'd3,
        ST_JAM    = 3'd4
    } dec_state_t;

    localparam int COIN5_PULSES  = 1;
    localparam int COIN10_PULSES = 2;

    localparam int COIN5_VALUE   = 5;
    localparam int COIN10_VALUE  = 10;

    // Pulse count sticks at 3: anything beyond two pulses is malformed anyway.
    function automatic logic [1:0] cnt_sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// -----------------------------------------------------------------------------
// pulse_sync
//   Multi-flop synchronizer for a single asynchronous level.
//   Ports:
//     i_clk    in  destination clock
//     i_reset  in  asynchronous, active-high reset (chain clears to 0)
//     i_async  in  asynchronous input level
//     o_sync   out synchronized level, SYNC_STAGES cycles behind i_async
// -----------------------------------------------------------------------------
module pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/coin_pulse_decoder.sv
// -----------------------------------------------------------------------------
// coin_pulse_decoder
//   Turns the coin validator's raw pulse train into one-cycle coin strobes.
//   One valid pulse = 5 units, two = 10 units. Short pulses are ignored as
//   glitches, three or more pulses or a stuck-high line produce a reject, and
//   any decoded coin is rejected while enable is low.
//   Ports:
//     clk         in   system clock
//     reset       in   asynchronous, active-high reset
//     coin_pulse  in   raw validator output (asynchronous, active-high)
//     enable      in   1 = accept coins, 0 = return them (sampled at decode)
//     coin5       out  one-cycle strobe, 5-unit coin accepted
//     coin10      out  one-cycle strobe, 10-unit coin accepted
//     reject      out  one-cycle strobe, coin returned / malformed / jam
//     busy        out  high while the decoder is not idle
// -----------------------------------------------------------------------------
module coin_pulse_decoder
    import vm_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PULSE   = 4,
    parameter int MAX_PULSE   = 64,
    parameter int GAP_CYCLES  = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_pulse,
    input  logic enable,
    output logic coin5,
    output logic coin10,
    output logic reject,
    output logic busy
);

    localparam int WIDTH_W = $clog2(MAX_PULSE + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(MAX_PULSE);
    localparam logic [WIDTH_W-1:0] WIDTH_MIN = WIDTH_W'(MIN_PULSE);
    localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(GAP_CYCLES);

    function automatic logic [WIDTH_W-1:0] width_inc(input logic [WIDTH_W-1:0] v);
        return (v == WIDTH_MAX) ? v : v + WIDTH_W'(1);
    endfunction

    function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] v);
        return (v == GAP_MAX) ? v : v + GAP_W'(1);
    endfunction

    logic               w_s;
    dec_state_t         r_state,  w_state_nxt;
    logic [WIDTH_W-1:0] r_width,  w_width_nxt;
    logic [GAP_W-1:0]   r_gap,    w_gap_nxt;
    logic [1:0]         r_cnt,    w_cnt_nxt;
    logic               r_coin5,  w_coin5_nxt;
    logic               r_coin10, w_coin10_nxt;
    logic               r_reject, w_reject_nxt;
    logic               r_busy,   w_busy_nxt;

    pulse_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (coin_pulse),
        .o_sync  (w_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_width  <= '0;
            r_gap    <= '0;
            r_cnt    <= '0;
            r_coin5  <= 1'b0;
            r_coin10 <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_width  <= w_width_nxt;
            r_gap    <= w_gap_nxt;
            r_cnt    <= w_cnt_nxt;
            r_coin5  <= w_coin5_nxt;
            r_coin10 <= w_coin10_nxt;
            r_reject <= w_reject_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_width_nxt  = r_width;
        w_gap_nxt    = r_gap;
        w_cnt_nxt    = r_cnt;
        w_coin5_nxt  = 1'b0;
        w_coin10_nxt = 1'b0;
        w_reject_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_width_nxt = WIDTH_W'(1);
                end
            end

            ST_HIGH: begin
                // A full-length high is a jam regardless of the current line level.
                if (r_width == WIDTH_MAX) begin
                    w_state_nxt  = ST_JAM;
                    w_gap_nxt    = '0;
                    w_reject_nxt = 1'b1;
                end else if (w_s) begin
                    w_width_nxt = width_inc(r_width);
                end else if (r_width >= WIDTH_MIN) begin
                    w_cnt_nxt   = cnt_sat_inc(r_cnt);
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_W'(1);
                end else if (r_cnt == 2'd0) begin
                    // Lone glitch: nothing worth waiting for.
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Glitch inside a train: restart the gap timer, keep the count.
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = GAP_W'(1);
                end
            end

            ST_GAP: begin
                if (r_gap == GAP_MAX) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_width_nxt = WIDTH_W'(1);
                end else begin
                    w_gap_nxt = gap_inc(r_gap);
                end
            end

            ST_DECODE: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                if (!enable) begin
                    w_reject_nxt = 1'b1;
                end else if (r_cnt == 2'(COIN5_PULSES)) begin
                    w_coin5_nxt = 1'b1;
                end else if (r_cnt == 2'(COIN10_PULSES)) begin
                    w_coin10_nxt = 1'b1;
                end else begin
                    w_reject_nxt = 1'b1;
                end
            end

            ST_JAM: begin
                // Wait for the line to stay low a full gap before listening again.
                if (r_gap == GAP_MAX) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_s) begin
                    w_gap_nxt = '0;
                end else begin
                    w_gap_nxt = gap_inc(r_gap);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Registered from the next state so busy lines up with the state register.
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign coin5  = r_coin5;
    assign coin10 = r_coin10;
    assign reject = r_reject;
    assign busy   = r_busy;

endmodule
